fnd_display_ctrl: RTL

//  4-digit common-anode 7-segment (FND) display controller; sits directly downstream of the

---
 rtl/fnd_display_ctrl_if.sv | 12 +
 rtl/fnd_display_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/fnd_display_ctrl_if.sv
// Bus bundle between the value producer and the FND display controller.
// The controller takes the slave side; the producer or bench takes the master side.
interface fnd_display_ctrl_if;
   logic [7:0] data_in;
   logic       in_en;
   logic       busy;
   logic [3:0] fnd_com;
   logic [7:0] fnd_font;

   modport master (output data_in, in_en, input busy, fnd_com, fnd_font);
   modport slave  (input data_in, in_en, output busy, fnd_com, fnd_font);
endinterface

// File: rtl/fnd_display_ctrl.sv
// 4-digit common-anode FND controller: 8-bit binary -> BCD by sequential double-dabble, then digit scan.
// Define FND_BLANK_EN to blank leading zeros; otherwise all four digits show numerals.
module fnd_display_ctrl #(
   parameter int SCAN_DIV = 100_000
) (
   input  logic clk,
   input  logic reset,
   fnd_display_ctrl_if.slave bus
);

   localparam int PW = $clog2(SCAN_DIV);

   typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

   state_t        state;
   logic [19:0]   shift_reg;
   logic [2:0]    iter;
   logic [7:0]    pend_val;
   logic          pend_flag;
   logic          busy_q;
   logic [3:0]    hund;
   logic [3:0]    tens;
   logic [3:0]    ones;
   logic [PW-1:0] prescaler;
   logic [1:0]    idx;
   logic [3:0]    com_q;
   logic [7:0]    font_q;
   logic [7:0]    digit_font;

   function automatic logic [7:0] seg(input logic [3:0] d);
      case (d)
         4'd0:    seg = 8'hC0;
         4'd1:    seg = 8'hF9;
         4'd2:    seg = 8'hA4;
         4'd3:    seg = 8'hB0;
         4'd4:    seg = 8'h99;
         4'd5:    seg = 8'h92;
         4'd6:    seg = 8'h82;
         4'd7:    seg = 8'hF8;
         4'd8:    seg = 8'h80;
         4'd9:    seg = 8'h90;
         default: seg = 8'hFF;
      endcase
   endfunction

   // One double-dabble step: correct every BCD nibble that would overflow, then shift.
   function automatic logic [19:0] dabble(input logic [19:0] s);
      logic [19:0] t;
      t = s;
      for (int i = 2; i < 5; i++) begin
         if (t[i*4 +: 4] >= 4'd5) t[i*4 +: 4] = t[i*4 +: 4] + 4'd3;
      end
      dabble = {t[18:0], 1'b0};
   endfunction

   // A strobe arriving in LOAD is the newest value, so it overrides any pending one.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         shift_reg <= '0;
         iter      <= '0;
         pend_val  <= '0;
         pend_flag <= 1'b0;
         busy_q    <= 1'b0;
         hund      <= '0;
         tens      <= '0;
         ones      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_en) begin
                  shift_reg <= {12'b0, bus.data_in};
                  iter      <= '0;
                  busy_q    <= 1'b1;
                  state     <= SHIFT;
               end
            end
            SHIFT: begin
               shift_reg <= dabble(shift_reg);
               iter      <= iter + 3'd1;
               if (iter == 3'd7) state <= LOAD;
               if (bus.in_en) begin
                  pend_val  <= bus.data_in;
                  pend_flag <= 1'b1;
               end
            end
            LOAD: begin
               hund <= shift_reg[19:16];
               tens <= shift_reg[15:12];
               ones <= shift_reg[11:8];
               if (pend_flag || bus.in_en) begin
                  shift_reg <= {12'b0, (bus.in_en ? bus.data_in : pend_val)};
                  iter      <= '0;
                  pend_flag <= 1'b0;
                  state     <= SHIFT;
               end else begin
                  busy_q <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prescaler <= '0;
         idx       <= '0;
      end else if (prescaler == PW'(SCAN_DIV - 1)) begin
         prescaler <= '0;
         idx       <= idx + 2'd1;
      end else begin
         prescaler <= prescaler + PW'(1);
      end
   end

   always_comb begin
      digit_font = 8'hC0;
      case (idx)
`ifdef FND_BLANK_EN
         2'd0: digit_font = seg(ones);
         2'd1: digit_font = (hund == 4'd0 && tens == 4'd0) ? 8'hFF : seg(tens);
         2'd2: digit_font = (hund == 4'd0) ? 8'hFF : seg(hund);
         2'd3: digit_font = 8'hFF;
`else
         2'd0: digit_font = seg(ones);
         2'd1: digit_font = seg(tens);
         2'd2: digit_font = seg(hund);
         2'd3: digit_font = seg(4'd0);
`endif
         default: digit_font = 8'hC0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         com_q  <= 4'b1110;
         font_q <= 8'hC0;
      end else begin
         com_q  <= ~(4'b0001 << idx);
         font_q <= digit_font;
      end
   end

   assign bus.busy     = busy_q;
   assign bus.fnd_com  = com_q;
   assign bus.fnd_font = font_q;

endmodule
